// File: rtl/sap1_memory_unit.sv
// SAP-1 memory unit: 4-bit MAR, 16x8 RAM on the W bus, and a byte-stream
// program loader that fills the RAM from address 0 with a running checksum.
module sap1_memory_unit #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              Lm,
  input  logic              Ce,
  input  logic              we,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [DATA_W-1:0] checksum,
  output logic              err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [3:0]        mar;
  logic [3:0]        ptr;
  logic [DATA_W-1:0] ram [16];
  logic [DATA_W-1:0] csum;
  logic              err_q;
  logic              live;
  logic              run_wr;
  logic              xfer;
  logic              fault;

  // Only the low nibble of the bus addresses the RAM.
  wire unused_bus_hi = ^bus_in[DATA_W-1:4];

  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  assign run_wr = !prog_mode && we && !Ce;
  assign xfer   = (state == LOAD) && prog_mode && prog_valid;
  assign fault  = prog_mode ? (Lm || Ce || we) : (Ce && we);

  // Reset release is registered so the release edge itself never acts.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      ptr   <= '0;
      csum  <= '0;
    end else if (live) begin
      if (!prog_mode) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            state <= LOAD;
            ptr   <= '0;
            csum  <= '0;
          end
          LOAD: begin
            if (prog_valid) begin
              ptr  <= ptr + 4'd1;
              csum <= csum_add(csum, prog_data);
              if (ptr == 4'd15) state <= DONE;
            end
          end
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                       mar <= '0;
    else if (live && !prog_mode && Lm) mar <= bus_in[3:0];
  end

  // Writes use the MAR value from before any same-edge Lm load.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
    end else if (live) begin
      if (xfer)        ram[ptr] <= prog_data;
      else if (run_wr) ram[mar] <= bus_in;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)             err_q <= 1'b0;
    else if (live && fault) err_q <= 1'b1;
  end

  assign bus_out    = ram[mar];
  assign bus_oe     = Ce && !prog_mode;
  assign prog_ready = (state == LOAD) && prog_mode;
  assign prog_done  = (state == DONE);
  assign checksum   = csum;
  assign err        = err_q;

endmodule
